// File: rtl/soc_periph_demux.sv
// Routes one upstream request at a time to the decoded peripheral: hit -> response 3 cycles at best, miss -> 1 cycle.
// Upstream backpressure holds RESP stable. A transaction stalled past TimeoutCycles is answered with an error.
module soc_periph_demux #(
  parameter int unsigned NbPeriph      = 10,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [63:0]              req_addr_i,
  input  logic                     req_we_i,
  input  logic [63:0]              req_wdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [63:0]              rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic [NbPeriph-1:0]      per_req_valid_o,
  input  logic [NbPeriph-1:0]      per_req_ready_i,
  output logic [63:0]              per_addr_o,
  output logic                     per_we_o,
  output logic [63:0]              per_wdata_o,
  input  logic [NbPeriph-1:0]      per_rsp_valid_i,
  output logic [NbPeriph-1:0]      per_rsp_ready_o,
  input  logic [NbPeriph-1:0][63:0] per_rsp_rdata_i,
  input  logic [NbPeriph-1:0]      per_rsp_err_i
);
  localparam int unsigned IdxW  = (NbPeriph > 1) ? $clog2(NbPeriph) : 1;
  localparam int unsigned CntW  = $clog2(TimeoutCycles);
  localparam int unsigned NbMap = 10;

  // Indexed in peripheral order: DRAM, GPIO, Ethernet, SPI, Timer, UART, PLIC, CLINT, ROM, Debug
  localparam logic [63:0] Base [NbMap] = '{
    64'h8000_0000, 64'h4000_0000, 64'h3000_0000, 64'h2000_0000, 64'h1800_0000,
    64'h1000_0000, 64'h0C00_0000, 64'h0200_0000, 64'h0001_0000, 64'h0000_0000};
  localparam logic [63:0] Len [NbMap] = '{
    64'h4000_0000, 64'h0000_1000, 64'h0001_0000, 64'h0080_0000, 64'h0000_1000,
    64'h0000_1000, 64'h03FF_FFFF, 64'h000C_0000, 64'h0001_0000, 64'h0000_1000};

  typedef enum logic [1:0] {Idle, Req, Wait, Resp} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, dec_idx;
  logic                dec_hit;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [63:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [63:0]         addr_q, wdata_q;
  logic                we_q;
  logic                timeout;
  logic [NbPeriph-1:0] sel;

  // 65-bit compare so a region ending at the top of the space cannot wrap
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = 0; i < int'(NbMap); i++) begin
      if (i < int'(NbPeriph) &&
          {1'b0, req_addr_i} >= {1'b0, Base[i]} &&
          {1'b0, req_addr_i} <  {1'b0, Base[i]} + {1'b0, Len[i]}) begin
        dec_hit = 1'b1;
        dec_idx = IdxW'(i);
      end
    end
  end

  assign sel     = NbPeriph'(1) << idx_q;
  assign timeout = (cnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    req_ready_o     = 1'b0;
    rsp_valid_o     = 1'b0;
    per_req_valid_o = '0;
    per_rsp_ready_o = '0;
    unique case (state_q)
      Idle: begin
        req_ready_o     = 1'b1;
        per_rsp_ready_o = '1;
        if (req_valid_i) begin
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = !dec_hit;
          state_d = dec_hit ? Req : Resp;
        end
      end
      Req: begin
        per_req_valid_o = sel;
        if (per_req_ready_i[idx_q]) begin
          // Counter saturates so WAIT still times out if the request slipped in on the last cycle
          state_d = Wait;
          if (!timeout) cnt_d = cnt_q + CntW'(1);
        end else if (timeout) begin
          state_d = Resp;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      Wait: begin
        per_rsp_ready_o = sel;
        if (per_rsp_valid_i[idx_q]) begin
          state_d = Resp;
          err_d   = per_rsp_err_i[idx_q];
          rdata_d = we_q ? 64'd0 : per_rsp_rdata_i[idx_q];
        end else if (timeout) begin
          state_d = Resp;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      Resp: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = Idle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= Idle;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      idx_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == Idle && req_valid_i) begin
        addr_q  <= req_addr_i;
        we_q    <= req_we_i;
        wdata_q <= req_wdata_i;
        idx_q   <= dec_idx;
      end
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign per_addr_o  = addr_q;
  assign per_we_o    = we_q;
  assign per_wdata_o = wdata_q;

endmodule

// File: doc/soc_periph_demux.md
SOC_PERIPH_DEMUX -- requirements
Module: soc_periph_demux

Interface
REQ-001 SHALL have parameters: NbPeriph, default 10, number of peripheral ports (index = axi_slaves_t order: DRAM=0 … Debug=9); TimeoutCycles, default 1024, response timeout in cycles (>=2).
REQ-002 SHALL have ports, clock and reset first:
- clk_i  in  1  sole clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  upstream request valid.
- req_ready_o  out  1  upstream request ready.
- req_addr_i  in  64  byte address.
- req_we_i  in  1  1=write, 0=read.
- req_wdata_i  in  64  write data.
- rsp_valid_o  out  1  upstream response valid.
- rsp_ready_i  in  1  upstream response ready.
- rsp_rdata_o  out  64  read data.
- rsp_err_o  out  1  1=decode error or timeout.
- per_req_valid_o  out  NbPeriph  one-hot request valid.
- per_req_ready_i  in  NbPeriph  peripheral request ready.
- per_addr_o  out  64  registered full address.
- per_we_o  out  1  registered write enable.
- per_wdata_o  out  64  registered write data.
- per_rsp_valid_i  in  NbPeriph  peripheral response valid.
- per_rsp_ready_o  out  NbPeriph  peripheral response ready.
- per_rsp_rdata_i  in  NbPeriph x 64  peripheral read data.
- per_rsp_err_i  in  NbPeriph  peripheral error.

Function
REQ-003 SHALL decode hit on port i iff Base_i <= addr < Base_i + Length_i: Debug 0x0/0x1000, ROM 0x1_0000/0x1_0000, CLINT 0x200_0000/0xC_0000, PLIC 0xC00_0000/0x3FF_FFFF, UART 0x1000_0000/0x1000, Timer 0x1800_0000/0x1000, SPI 0x2000_0000/0x80_0000, Ethernet 0x3000_0000/0x1_0000, GPIO 0x4000_0000/0x1000, DRAM 0x8000_0000/0x4000_0000; compare in 65 bits, no wrap.
REQ-004 SHALL implement FSM IDLE, REQ, WAIT, RESP; one outstanding transaction.
REQ-005 IDLE: req_ready_o=1; on req_valid_i register addr/we/wdata and decoded index; hit -> REQ, miss -> RESP with rsp_err_o=1, rsp_rdata_o=0.
REQ-006 REQ: per_req_valid_o[idx]=1 only; on per_req_ready_i[idx] -> WAIT; per_addr_o/per_we_o/per_wdata_o stable throughout.
REQ-007 WAIT: per_rsp_ready_o[idx]=1; on per_rsp_valid_i[idx] capture rdata/err -> RESP.
REQ-008 RESP: rsp_valid_o=1, data/err held stable until rsp_ready_i, then IDLE; req_ready_o=0 outside IDLE.
REQ-009 Minimum latency: hit accepted cycle 0 -> per_req_valid_o cycle 1; peripheral ready+response same cycle as each phase -> rsp_valid_o cycle 3; miss -> rsp_valid_o cycle 1.
REQ-010 Timeout counter SHALL clear on entering REQ, increment each cycle in REQ/WAIT; reaching TimeoutCycles-1 without completion -> RESP, rsp_err_o=1, rsp_rdata_o=0, per_req_valid_o deasserted.
REQ-011 Handshake completing on the same cycle as the timeout SHALL win (normal result, no error).
REQ-012 In IDLE per_rsp_ready_o SHALL be all-ones; stale responses are drained and discarded; in REQ/RESP all zeros.
REQ-013 per_req_valid_o and per_rsp_ready_o SHALL be at most one-hot outside IDLE.
REQ-014 Write responses SHALL return rsp_rdata_o=0 regardless of peripheral rdata.

Reset
REQ-015 On rst_ni low, asynchronously: state IDLE, counter 0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, per_req_valid_o=0, per_addr_o=0, per_we_o=0, per_wdata_o=0; req_ready_o=1 and per_rsp_ready_o all-ones once released.
REQ-016 Reset mid-transaction SHALL abandon it with no upstream response.

Verification
REQ-017 Read 0x1000_0008, UART ready/responds immediately rdata=0xAB -> per_req_valid_o=0x020 cycle 1, rsp_valid_o cycle 3, rdata 0xAB, err 0.
REQ-018 Read 0x5000_0000 -> no per_req_valid_o, rsp_valid_o cycle 1, err=1, rdata=0.
REQ-019 Boundaries: 0xBFFF_FFFF -> DRAM (bit0); 0xC000_0000 -> err; 0x0 -> Debug (bit9); 0x1000 -> err.
REQ-020 Write 0x0200_4000 to CLINT never responding, TimeoutCycles=16 -> err=1 after 16 cycles in REQ/WAIT; late CLINT response in IDLE drained, no rsp_valid_o.
REQ-021 rsp_ready_i held low 5 cycles in RESP -> rsp_* stable, req_ready_o=0; release -> IDLE next cycle.
REQ-022 rst_ni asserted in WAIT -> outputs at reset values immediately, next request decoded normally.
